icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and a slow word-serial instruction memory.
- Fetch presents the PC every cycle. On a hit the cache returns the instruction in the same cycle.
- On a miss it asserts stall, which drives write_PC/write_IFID low, and refills the whole line from memory one word per beat.
- After the refill it resumes serving hits.

Parameters:
- LINE_WORDS, 4, words per line; power of 2, >=2.
- NUM_LINES, 16, number of lines; power of 2, >=2.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  fetch is requesting an instruction this cycle.
- req_addr  in  32  fetch PC (byte address); bits [1:0] are ignored.
- instr  out  32  instruction word; valid only when hit=1.
- hit  out  1  req_valid & tag match & line valid & state==IDLE.
- stall  out  1  freezes PC and IF_ID.
- inv  in  1  one-cycle pulse that invalidates all lines.
- mem_req  out  1  memory read request; held high until the beat is accepted.
- mem_addr  out  32  word-aligned address of the requested beat.
- mem_rdata  in  32  returned word.
- mem_rvalid  in  1  mem_rdata is valid; completes the current beat.
- hit_count  out  32  hit counter (see Optional Feature).
- miss_count  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split: offset = req_addr[2+OB-1:2], with OB=log2(LINE_WORDS). Index = next log2(NUM_LINES) bits. Tag = remaining upper bits.
- Storage: data array of NUM_LINES*LINE_WORDS x 32, plus per-line tag and valid bit.
- Reset (rst=0, asynchronous):
  - state=IDLE, all valid bits=0, beat=0.
  - mem_req=0, mem_addr=0, stall=0, hit=0, instr=0.
  - Counters=0.
  - Reset mid-refill aborts the refill immediately; no partial line is marked valid.
- State IDLE:
  - hit/instr are combinational from req_addr (zero-latency hit).
  - If req_valid & !hit: stall=1 in that same cycle. Latch the miss tag/index, beat=0, go to REFILL.
  - If req_valid=0: stall=0, no action.
- State REFILL:
  - stall=1, mem_req=1, mem_addr = {tag,index,beat,2'b00}.
  - On mem_rvalid: write mem_rdata into data[index][beat], then beat++.
  - When the beat that completes is LINE_WORDS-1: write the tag, set valid (unless an inv occurred during this refill), deassert mem_req in the next cycle, go to DONE.
  - mem_rvalid with mem_req=0 is ignored.
- State DONE: one cycle; stall=1, mem_req=0; go to IDLE. The re-presented PC then hits.
- Miss-to-hit latency: LINE_WORDS memory beats + 2 cycles.
- Refill order is always beat 0..LINE_WORDS-1; there is no critical-word-first.
- The fill address is the latched miss address; req_addr changes during REFILL/DONE (branch flush) are ignored. In IDLE the new PC is looked up normally.
- inv:
  - In IDLE, all valid bits are cleared at the clock edge; hit in that same cycle still uses the old valid bits.
  - In REFILL, valid bits are cleared and a pending flag ensures the line under refill is not marked valid. It refetches on the next access.
- The same line re-missing after an eviction (index conflict) simply refills and overwrites the old line.
- hit=0 whenever state!=IDLE.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_count increments each IDLE cycle with req_valid & hit.
  - miss_count increments on each IDLE->REFILL transition.
  - Both saturate at 32'hFFFFFFFF and are cleared only by rst.
- Undefined: no counter flops; both outputs are tied to 32'h0.

Test Plan:
1. Cold miss: after reset, req_addr=0x00000040. Expect:
   - stall=1 immediately; mem_addr sequence 0x40,0x44,0x48,0x4C.
   - Memory returns 0x11,0x22,0x33,0x44 with 1-cycle rvalid each.
   - DONE cycle, then hit=1, instr=0x11; total stall 6 cycles.
2. Sequential hits: after test 1, req_addr=0x44,0x48,0x4C on consecutive cycles. Expect hit=1, stall=0, instr=0x22,0x33,0x44; no mem_req.
3. Conflict eviction: req_addr=0x00000140 (same index 4, tag 1). Expect:
   - Miss and refill of 0x140..0x14C.
   - Then 0x40 misses again and refills.
4. Invalidate during refill: miss on 0x80, pulse inv on beat 1. Expect:
   - Refill completes, line not valid.
   - The next 0x80 request misses again; earlier line 0x40 also misses.
5. Async reset mid-refill: drop rst during beat 2 of a refill. Expect mem_req=0, stall=0 without a clock edge; the same address then misses after release.
6. Stats (ICACHE_STATS_EN defined): run tests 1-2. Expect miss_count=1, hit_count=4. With the macro undefined, both read 0.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache.
// Hits return in the same cycle; a miss stalls fetch and refills the whole
// line beat 0..LINE_WORDS-1 from a word-serial memory.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic [31:0] instr,
    output logic        hit,
    output logic        stall,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 30 - OB - IB;

    typedef enum logic [1:0] {IDLE, REFILL, DONE} stateT;

    stateT               state;
    logic [OB-1:0]       beat;
    logic [OB-1:0]       beatNext;
    logic [TW-1:0]       missTag;
    logic [IB-1:0]       missIdx;
    logic                invPending;
    logic                memReqQ;
    logic [31:0]         memAddrQ;
    logic [NUM_LINES-1:0] validBits;
    logic [31:0]         dataArr [NUM_LINES*LINE_WORDS];
    logic [TW-1:0]       tagArr  [NUM_LINES];

    logic [OB-1:0] reqOff;
    logic [IB-1:0] reqIdx;
    logic [TW-1:0] reqTag;
    logic          missNow;
    logic          accept;
    logic          lastBeat;
    logic [1:0]    unusedAddr;

    assign reqOff     = req_addr[2 +: OB];
    assign reqIdx     = req_addr[2+OB +: IB];
    assign reqTag     = req_addr[31 -: TW];
    assign unusedAddr = req_addr[1:0];
    assign beatNext   = beat + OB'(1);

    // Lookup is gated by rst so hit/stall drop immediately on an asynchronous reset.
    assign hit      = rst & req_valid & (state == IDLE) & validBits[reqIdx]
                      & (tagArr[reqIdx] == reqTag);
    assign instr    = hit ? dataArr[{reqIdx, reqOff}] : 32'h0;
    assign missNow  = rst & req_valid & (state == IDLE) & ~hit;
    assign stall    = missNow | (rst & (state != IDLE));
    assign accept   = (state == REFILL) & memReqQ & mem_rvalid;
    assign lastBeat = accept & (beat == OB'(LINE_WORDS - 1));
    assign mem_req  = memReqQ;
    assign mem_addr = memAddrQ;

    // Miss/refill sequencer; the fill address comes only from the latched miss.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= '0;
            missTag    <= '0;
            missIdx    <= '0;
            invPending <= 1'b0;
            memReqQ    <= 1'b0;
            memAddrQ   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (missNow) begin
                    missTag    <= reqTag;
                    missIdx    <= reqIdx;
                    beat       <= '0;
                    invPending <= 1'b0;
                    memReqQ    <= 1'b1;
                    memAddrQ   <= {reqTag, reqIdx, {OB{1'b0}}, 2'b00};
                    state      <= REFILL;
                end
                REFILL: begin
                    if (inv) invPending <= 1'b1;
                    if (accept) begin
                        beat     <= beatNext;
                        memAddrQ <= {missTag, missIdx, beatNext, 2'b00};
                        if (lastBeat) begin
                            memReqQ <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Valid bits: inv wins over a completing refill; an inv seen mid-refill keeps the line invalid.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst)                         validBits <= '0;
        else if (inv)                     validBits <= '0;
        else if (lastBeat && !invPending) validBits[missIdx] <= 1'b1;
    end

    // Data and tag storage; only written by accepted refill beats.
    always_ff @(posedge clock) begin
        if (accept)   dataArr[{missIdx, beat}] <= mem_rdata;
        if (lastBeat) tagArr[missIdx] <= missTag;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hitCnt  <= 32'h0;
            missCnt <= 32'h0;
        end else begin
            if (hit && hitCnt != 32'hFFFF_FFFF)      hitCnt  <= hitCnt + 32'd1;
            if (missNow && missCnt != 32'hFFFF_FFFF) missCnt <= missCnt + 32'd1;
        end
    end

    assign hit_count  = hitCnt;
    assign miss_count = missCnt;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: scripted fetches against a memory model; expected
// refill addresses and hit data are queued when a fetch is issued and popped
// as the DUT produces them.
module tb_icache_ctrl;
    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] instr;
    logic        hit;
    logic        stall;
    logic        inv = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] addrQ [$];
    logic [31:0] instrQ [$];

    icache_ctrl #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
        .clock(clock), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .instr(instr), .hit(hit), .stall(stall), .inv(inv),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Memory model: line 0x40..0x4C holds 0x11..0x44, everything else a pattern.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h4) return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory answers every request with a one-cycle beat.
    assign mem_rvalid = mem_req;
    assign mem_rdata  = memWord(mem_addr);

    // Issue a fetch of a and follow it to completion. invBeat>=0 pulses inv
    // during that refill beat; dropAfter withdraws the request in the DONE cycle.
    task automatic fetch(input logic [31:0] a, input bit expMiss, input int invBeat,
                         input bit dropAfter);
        int stalls = 0;
        int beats = 0;
        bit done = 0;
        logic [31:0] expA;
        logic [31:0] expI;
        if (expMiss)
            for (int b = 0; b < 4; b++) addrQ.push_back({a[31:4], 4'h0} + 32'(b * 4));
        if (!dropAfter) instrQ.push_back(memWord(a));
        req_valid = 1'b1;
        req_addr  = a;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            if (!stall) done = 1;
            else begin
                stalls++;
                if (mem_req && mem_rvalid) begin
                    vectors++;
                    if (addrQ.size() == 0) begin
                        miscompares++;
                        $display("FAIL refill_addr: got %h with no beat expected", mem_addr);
                    end else begin
                        expA = addrQ.pop_front();
                        if (mem_addr !== expA) begin
                            miscompares++;
                            $display("FAIL refill_addr: got %h expected %h", mem_addr, expA);
                        end
                    end
                    inv = (beats == invBeat);
                    beats++;
                end
                if (dropAfter && beats == 4 && !mem_req) req_valid = 1'b0;
                @(posedge clock);
                #1 inv = 1'b0;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL fetch_timeout: addr %h still stalled after 40 cycles", a);
        end
        vectors++;
        if (stalls != (expMiss ? 6 : 0)) begin
            miscompares++;
            $display("FAIL stall_cycles %h: got %0d expected %0d", a, stalls, expMiss ? 6 : 0);
        end
        vectors++;
        if (addrQ.size() != 0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL refill_beats %h: %0d beats missing, mem_req %b expected 0",
                     a, addrQ.size(), mem_req);
            addrQ.delete();
        end
        if (!dropAfter) begin
            expI = instrQ.pop_front();
            vectors++;
            if (hit !== 1'b1 || instr !== expI) begin
                miscompares++;
                $display("FAIL hit_data %h: got hit=%b instr=%h expected hit=1 instr=%h",
                         a, hit, instr, expI);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h40;
        #3;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem: got req=%b addr=%h expected 0/0", mem_req, mem_addr);
        end
        vectors++;
        if (stall !== 1'b0 || hit !== 1'b0 || instr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_fetch: got stall=%b hit=%b instr=%h expected 0", stall, hit, instr);
        end
        vectors++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_counts: got %h/%h expected 0/0", hit_count, miss_count);
        end
        req_valid = 1'b0;
        @(posedge clock);
        #1 rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        fetch(32'h40, 1, -1, 0);
    endtask

    task automatic test_back_to_back();
        fetch(32'h44, 0, -1, 0);
        fetch(32'h48, 0, -1, 0);
        fetch(32'h4C, 0, -1, 0);
    endtask

    task automatic test_stats();
        logic [31:0] expHits;
        logic [31:0] expMisses;
`ifdef ICACHE_STATS_EN
        expHits = 32'd4;
        expMisses = 32'd1;
`else
        expHits = 32'd0;
        expMisses = 32'd0;
`endif
        req_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (hit_count !== expHits || miss_count !== expMisses) begin
            miscompares++;
            $display("FAIL stats: got hits=%0d misses=%0d expected %0d/%0d",
                     hit_count, miss_count, expHits, expMisses);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_conflict();
        fetch(32'h140, 1, -1, 0);
        fetch(32'h40, 1, -1, 0);
        fetch(32'h140, 1, -1, 0);
        fetch(32'h40, 1, -1, 0);
    endtask

    task automatic test_inv_idle();
        req_valid = 1'b1;
        req_addr = 32'h40;
        inv = 1'b1;
        @(negedge clock);
        vectors++;
        if (hit !== 1'b1 || instr !== 32'h11 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_idle_same_cycle: got hit=%b instr=%h stall=%b expected 1/11/0",
                     hit, instr, stall);
        end
        req_valid = 1'b0;
        @(posedge clock);
        #1 inv = 1'b0;
        fetch(32'h40, 1, -1, 0);
    endtask

    task automatic test_inv_refill();
        fetch(32'h80, 1, 1, 1);
        fetch(32'h80, 1, -1, 0);
        fetch(32'h40, 1, -1, 0);
    endtask

    task automatic test_reset_refill();
        bit found = 0;
        req_valid = 1'b1;
        req_addr = 32'hC0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clock);
            if (mem_req && mem_rvalid && mem_addr == 32'hC8) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_refill_beat2: beat at c8 never seen, mem_addr=%h", mem_addr);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_refill_async: got req=%b stall=%b hit=%b expected 0/0/0",
                     mem_req, stall, hit);
        end
        req_valid = 1'b0;
        @(posedge clock);
        #1 rst = 1'b1;
        fetch(32'hC0, 1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_stats();
        test_conflict();
        test_inv_idle();
        test_inv_refill();
        test_reset_refill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
